// File: rtl/clz_pkg.sv
// Shared definitions for the leading/trailing bit-count sequencer:
// op encodings, result width and the output buffer entry layout.
package clz_pkg;

    localparam int CLZ_RES_W = 6;
    localparam logic [CLZ_RES_W-1:0] CLZ_ALL_ZERO = 6'd32;

    typedef enum logic [1:0] {
        CLZ_OP_CLZ = 2'b00,
        CLZ_OP_CLO = 2'b01,
        CLZ_OP_CTZ = 2'b10,
        CLZ_OP_CTO = 2'b11
    } clz_op_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Occupancy lives in the FSM state and the tag beside the entry, since the
    // tag width is a parameter of the scheduler rather than of this package.
    typedef struct packed {
        logic                 owner;
        logic [CLZ_RES_W-1:0] result;
    } clz_entry_t;

endpackage

// File: rtl/clz.sv
// 32-bit leading-zero counter. An all-zero input yields 0; callers that need
// the 32 result must detect that case themselves.
module clz (
    input  logic [31:0] data,
    output logic [4:0]  count
);

    // Later iterations override earlier ones, so the highest set bit wins.
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (data[i]) count = 5'(31 - i);
        end
    end

endmodule

// File: rtl/clz_sched.sv
// Round-robin sequencer for the shared leading-zero counter: preprocesses the
// granted operand for CLZ/CLO/CTZ/CTO and returns results from a one-entry buffer.
module clz_sched
    import clz_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [63:0]          req_data,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [CLZ_RES_W-1:0] rsp_result,
    output logic [TAG_W-1:0]     rsp_tag
);

    buf_state_e           state, state_nxt;
    clz_entry_t           entry;
    logic [TAG_W-1:0]     entry_tag;
    logic                 ptr;
    logic                 full, pop, can_accept, kill0, grant, gnt_port;
    logic [1:0]           eligible;
    clz_op_e              op_sel;
    logic [31:0]          data_sel, inv_word, word;
    logic [TAG_W-1:0]     tag_sel;
    logic [4:0]           cnt;
    logic [CLZ_RES_W-1:0] result;

    assign full       = (state == BUF_FULL);
    assign pop        = full & rsp_ready[entry.owner];
    assign can_accept = ~full | pop;
    assign kill0      = flush & full & ~entry.owner;

    // Flush masks port 0 out of arbitration; the pointer only moves on a real grant.
    assign eligible = {req_valid[1], req_valid[0] & ~flush};

    always_comb begin
        gnt_port = 1'b0;
        case (eligible)
            2'b01:   gnt_port = 1'b0;
            2'b10:   gnt_port = 1'b1;
            2'b11:   gnt_port = ptr;
            default: gnt_port = 1'b0;
        endcase
    end

    // Gated by resetn so req_ready reads 00 throughout reset.
    assign grant = resetn & can_accept & (|eligible);

    assign op_sel   = clz_op_e'(gnt_port ? req_op[3:2] : req_op[1:0]);
    assign data_sel = gnt_port ? req_data[63:32] : req_data[31:0];
    assign tag_sel  = gnt_port ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

    // Counting ones is counting zeros of the complement; trailing counts are
    // leading counts of the bit-reversed word.
    always_comb begin
        inv_word = (op_sel == CLZ_OP_CLO || op_sel == CLZ_OP_CTO) ? ~data_sel : data_sel;
        word     = inv_word;
        if (op_sel == CLZ_OP_CTZ || op_sel == CLZ_OP_CTO) begin
            for (int i = 0; i < 32; i++) word[i] = inv_word[31-i];
        end
    end

    clz u_clz (
        .data  (word),
        .count (cnt)
    );

    assign result = (word == 32'd0) ? CLZ_ALL_ZERO : {1'b0, cnt};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= BUF_EMPTY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BUF_EMPTY: if (grant) state_nxt = BUF_FULL;
            BUF_FULL:  if (!grant && (pop || kill0)) state_nxt = BUF_EMPTY;
            default:   state_nxt = BUF_EMPTY;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (grant) req_ready[gnt_port] = 1'b1;
        if (state == BUF_FULL) rsp_valid[entry.owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry     <= '0;
            entry_tag <= '0;
            ptr       <= 1'b0;
        end else if (grant) begin
            entry     <= '{owner: gnt_port, result: result};
            entry_tag <= tag_sel;
            ptr       <= ~gnt_port;
        end
    end

    assign rsp_result = entry.result;
    assign rsp_tag    = entry_tag;

endmodule

// File: doc/clz_sched.md
# clz_sched

Sequencer and arbiter for the shared 32-bit leading-zero counter in the integer execution cluster. Two requesters compete for the single counter: port 0 is the execute-stage ALU bit-count path and port 1 is divider operand normalisation. The block supports four operations, CLZ, CLO, CTZ and CTO, and resolves the all-zero case that the counter cannot express. Each result is registered and returned to its owner over a valid/ready response channel.

## Interface
- TAG_W, default 4: width of the opaque tag carried from request to response.
- clk  in  1: clock; all state updates on the rising edge.
- resetn  in  1: asynchronous, active-low reset.
- flush  in  1: kill pending port-0 work; asserted by the pipeline on a redirect.
- req_valid  in  2: per port, request valid (bit n = port n).
- req_ready  out  2: per port, request accepted this cycle.
- req_op  in  2×2: per port, 00 CLZ, 01 CLO, 10 CTZ, 11 CTO.
- req_data  in  2×32: per port, operand.
- req_tag  in  2×TAG_W: per port, tag.
- rsp_valid  out  2: per port, response valid.
- rsp_ready  in  2: per port, consumer ready.
- rsp_result  out  6: count, 0..32; shared by both ports and qualified by rsp_valid.
- rsp_tag  out  TAG_W: tag of the current response.

## Operation
- Operand preprocessing for the granted request:
  - CLZ: operand as is.
  - CLO: bitwise inversion.
  - CTZ: bit reversal.
  - CTO: inversion, then bit reversal.
- The preprocessed word drives the counter. The 5-bit count is zero-extended to 6 bits.
- If the preprocessed word is 0, the result is forced to 32, whatever the counter outputs.
- Output buffer: one entry with {full, owner, result, tag}. Two states, EMPTY and FULL.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on a handshake (rsp_valid[owner] & rsp_ready[owner]) with no new grant.
  - FULL stays FULL on a handshake plus a new grant (back-to-back).
- Accept condition: `can_accept = !full | (rsp_valid[owner] & rsp_ready[owner])`.
- Arbitration: round-robin between the two ports.
  - One priority pointer bit; it resets to port 0.
  - When both ports request, the port the pointer selects wins.
  - After any grant, the pointer moves to the other port. A lone requester is always granted and also moves the pointer.
- req_ready[n] is asserted only for the granted port, and only when can_accept is high. It is a combinational function of req_valid, the pointer, buffer state and rsp_ready. Requesters must hold valid, op, data and tag stable until ready is seen.
- rsp_valid[n] = full & (owner == n). The other port's rsp_valid is 0.
- flush:
  - Clears a FULL entry whose owner is 0.
  - Suppresses any port-0 grant in the same cycle.
  - Port 1 is unaffected: its buffered result stays and it may still be granted.
  - The pointer does not change because of flush.
- Reset mid-operation: the buffered entry is discarded. No response is produced for a request accepted before reset.

## Timing
- Reset values:
  - req_ready = 00, rsp_valid = 00, rsp_result = 0, rsp_tag = 0.
  - Pointer = port 0, state EMPTY.
- Latency: a request accepted in cycle t drives rsp_valid in cycle t+1.
- Throughput: one result per cycle when the consumer keeps rsp_ready high.
- Back-pressure: while the owner holds rsp_ready low, the entry and all outputs stay stable. Both req_ready bits stay 0.
- Same-cycle pop and grant: the new entry replaces the old one at the edge. No bubble is inserted.
- The counter and preprocessing are purely combinational between the request mux and the buffer register. There is no other pipeline stage.

## Structure
- Shared package clz_pkg:
  - Op encodings CLZ_OP_CLZ, CLZ_OP_CLO, CLZ_OP_CTZ, CLZ_OP_CTO.
  - CLZ_RES_W = 6 and CLZ_ALL_ZERO = 6'd32.
  - Typedef for the buffer entry struct.
- One sub-module: the existing `clz` counter, instantiated exactly once. Preprocessing, zero detection, arbitration and the buffer live in clz_sched itself.

## Test plan
- **Single port-0 CLZ:** port 0 sends CLZ on 0x0001_0000 with tag 3, rsp_ready held 1 → rsp_valid = 01 next cycle, result 15, tag 3.
- **Zero and all-ones corners:** CLZ on 0x0000_0000 → 32; CLO on 0xFFFF_FFFF → 32. CTZ on 0x8000_0000 → 31; CTO on 0x0000_00FF → 8.
- **Contention after reset:** both ports request every cycle, rsp_ready = 11 → grants alternate 0,1,0,1 starting with port 0. One response every cycle.
- **Back-pressure:** port 1 result held with rsp_ready[1] = 0 for 5 cycles → result and tag stable, req_ready = 00. Release → port 0, already waiting, is granted the same cycle.
- **Flush:** flush while a port-0 result is buffered and port 0 is requesting → rsp_valid[0] falls next cycle and no port-0 grant occurs. Repeat with a port-1 entry buffered → the entry survives.
- **Async reset:** assert resetn = 0 mid-response, between clock edges → all outputs go to zero immediately. After release, a CTZ on 0x10 produces 4.
